// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: resolves load-use stalls, taken-branch squashes and
// multi-cycle MEM accesses into PC / IF/ID / ID/EX / back-end enable and flush controls.
module hazard_stall_controller #(
    parameter int unsigned LOAD_BUBBLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  IF_ID_src1,
    input  logic [5:0]  IF_ID_src2,
    input  logic        IF_ID_src1_used,
    input  logic        IF_ID_src2_used,
    input  logic [5:0]  ID_EX_RD,
    input  logic        ID_EX_readEN,
    input  logic        EX_branch_taken,
    input  logic        mem_req,
    input  logic        mem_done,
    output logic        PC_EN,
    output logic        IF_ID_EN,
    output logic        IF_ID_flush,
    output logic        ID_EX_bubble,
    output logic        ID_EX_flush,
    output logic        pipe_hold,
    output logic        mem_error,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] LB_REMAIN  = 2'(LOAD_BUBBLES - 32'd1);
    localparam logic [7:0] TIMEOUT_V  = 8'(MEM_TIMEOUT);

    state_t      state_q,     state_d;
    state_t      resume_q,    resume_d;
    logic [1:0]  remaining_q, remaining_d;
    logic [7:0]  wait_cnt_q,  wait_cnt_d;
    logic        mem_error_q, mem_error_d;
    logic [15:0] stall_q,     stall_d;

    logic hazard_s;
    logic mem_stall_s;
    logic pc_en_s;
    logic if_id_en_s;
    logic if_id_flush_s;
    logic id_ex_bubble_s;
    logic id_ex_flush_s;
    logic pipe_hold_s;
    logic timeout_s;

    // Load in EX whose destination feeds a source actually read by the instruction in ID.
    always_comb begin
        hazard_s = ID_EX_readEN &&
                   ((IF_ID_src1_used && (IF_ID_src1 == ID_EX_RD)) ||
                    (IF_ID_src2_used && (IF_ID_src2 == ID_EX_RD)));
        mem_stall_s = mem_req && !mem_done;
    end

    // Next-state logic and Mealy control outputs; reset forces the idle output set.
    always_comb begin
        state_d        = state_q;
        resume_d       = resume_q;
        remaining_d    = remaining_q;
        wait_cnt_d     = wait_cnt_q;
        pc_en_s        = 1'b1;
        if_id_en_s     = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        id_ex_flush_s  = 1'b0;
        pipe_hold_s    = 1'b0;
        timeout_s      = 1'b0;

        if (rst) begin
            state_d     = ST_RUN;
            resume_d    = ST_RUN;
            remaining_d = 2'd0;
            wait_cnt_d  = 8'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall_s) begin
                        pc_en_s     = 1'b0;
                        if_id_en_s  = 1'b0;
                        pipe_hold_s = 1'b1;
                        state_d     = ST_MEM_WAIT;
                        wait_cnt_d  = 8'd1;
                        resume_d    = ST_RUN;
                    end else if (EX_branch_taken) begin
                        if_id_flush_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                        state_d       = ST_RUN;
                    end else if (hazard_s) begin
                        pc_en_s        = 1'b0;
                        if_id_en_s     = 1'b0;
                        id_ex_bubble_s = 1'b1;
                        if (LOAD_BUBBLES == 32'd1) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d     = ST_LOAD_STALL;
                            remaining_d = LB_REMAIN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end

                // Hazard and branch are not looked at here: EX already holds a bubble.
                ST_LOAD_STALL: begin
                    pc_en_s    = 1'b0;
                    if_id_en_s = 1'b0;
                    if (mem_stall_s) begin
                        pipe_hold_s = 1'b1;
                        state_d     = ST_MEM_WAIT;
                        wait_cnt_d  = 8'd1;
                        resume_d    = ST_LOAD_STALL;
                    end else begin
                        id_ex_bubble_s = 1'b1;
                        if (remaining_q <= 2'd1) begin
                            remaining_d = 2'd0;
                            state_d     = ST_RUN;
                        end else begin
                            remaining_d = remaining_q - 2'd1;
                            state_d     = ST_LOAD_STALL;
                        end
                    end
                end

                ST_MEM_WAIT: begin
                    pc_en_s    = 1'b0;
                    if_id_en_s = 1'b0;
                    if (mem_done) begin
                        state_d    = resume_q;
                        wait_cnt_d = 8'd0;
                    end else if (wait_cnt_q >= TIMEOUT_V) begin
                        // Abort: release the back end and drop any interrupted load stall.
                        timeout_s   = 1'b1;
                        state_d     = ST_RUN;
                        resume_d    = ST_RUN;
                        remaining_d = 2'd0;
                        wait_cnt_d  = 8'd0;
                    end else begin
                        pipe_hold_s = 1'b1;
                        wait_cnt_d  = wait_cnt_q + 8'd1;
                    end
                end

                default: begin
                    state_d     = ST_RUN;
                    resume_d    = ST_RUN;
                    remaining_d = 2'd0;
                    wait_cnt_d  = 8'd0;
                end
            endcase
        end
    end

    // Sticky timeout flag and saturating stall-cycle counter.
    always_comb begin
        if (timeout_s) begin
            mem_error_d = 1'b1;
        end else begin
            mem_error_d = mem_error_q;
        end

        if (!pc_en_s && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            resume_q    <= ST_RUN;
            remaining_q <= 2'd0;
            wait_cnt_q  <= 8'd0;
            mem_error_q <= 1'b0;
            stall_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            stall_q     <= stall_d;
        end
    end

    assign PC_EN        = pc_en_s;
    assign IF_ID_EN     = if_id_en_s;
    assign IF_ID_flush  = if_id_flush_s;
    assign ID_EX_bubble = id_ex_bubble_s;
    assign ID_EX_flush  = id_ex_flush_s;
    assign pipe_hold    = pipe_hold_s;
    assign mem_error    = mem_error_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: a per-cycle vector table on a
// LOAD_BUBBLES=2 / MEM_TIMEOUT=4 instance, plus hand sequences for timeout, reset and LOAD_BUBBLES=3.
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  src1, src2, rd;
    logic        u1, u2, ld, br, mq, md;

    logic        pc_a, ifen_a, iff_a, bub_a, exf_a, hold_a, err_a;
    logic [15:0] stall_a;
    logic        pc_b, ifen_b, iff_b, bub_b, exf_b, hold_b, err_b;
    logic [15:0] stall_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Control vector order: {PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_bubble, ID_EX_flush, pipe_hold}
    localparam logic [5:0] IDLE  = 6'b110000;
    localparam logic [5:0] BUB   = 6'b000100;
    localparam logic [5:0] FLUSH = 6'b111010;
    localparam logic [5:0] FRZ   = 6'b000001;
    localparam logic [5:0] REL   = 6'b000000;

    hazard_stall_controller #(.LOAD_BUBBLES(2), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst),
        .IF_ID_src1(src1), .IF_ID_src2(src2),
        .IF_ID_src1_used(u1), .IF_ID_src2_used(u2),
        .ID_EX_RD(rd), .ID_EX_readEN(ld), .EX_branch_taken(br),
        .mem_req(mq), .mem_done(md),
        .PC_EN(pc_a), .IF_ID_EN(ifen_a), .IF_ID_flush(iff_a),
        .ID_EX_bubble(bub_a), .ID_EX_flush(exf_a), .pipe_hold(hold_a),
        .mem_error(err_a), .stall_cycles(stall_a)
    );

    hazard_stall_controller #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst),
        .IF_ID_src1(src1), .IF_ID_src2(src2),
        .IF_ID_src1_used(u1), .IF_ID_src2_used(u2),
        .ID_EX_RD(rd), .ID_EX_readEN(ld), .EX_branch_taken(br),
        .mem_req(mq), .mem_done(md),
        .PC_EN(pc_b), .IF_ID_EN(ifen_b), .IF_ID_flush(iff_b),
        .ID_EX_bubble(bub_b), .ID_EX_flush(exf_b), .pipe_hold(hold_b),
        .mem_error(err_b), .stall_cycles(stall_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  s1;
        logic        u1;
        logic [5:0]  s2;
        logic        u2;
        logic [5:0]  rd;
        logic        ld;
        logic        br;
        logic        mq;
        logic        md;
        logic [5:0]  ctl;
        logic        err;
        logic [15:0] stall;
    } vec_t;

    vec_t tv[31];

    function automatic vec_t mk(input logic r, input logic [5:0] s1_i, input logic u1_i,
                                input logic [5:0] s2_i, input logic u2_i, input logic [5:0] rd_i,
                                input logic ld_i, input logic br_i, input logic mq_i, input logic md_i,
                                input logic [5:0] ctl_i, input logic err_i, input logic [15:0] st_i);
        vec_t v;
        v.rst = r;   v.s1 = s1_i; v.u1 = u1_i; v.s2 = s2_i; v.u2 = u2_i; v.rd = rd_i;
        v.ld = ld_i; v.br = br_i; v.mq = mq_i; v.md = md_i;
        v.ctl = ctl_i; v.err = err_i; v.stall = st_i;
        return v;
    endfunction

    task automatic chk_ctl(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: ctl got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_reg(input string nm, input logic err_act, input logic [15:0] st_act,
                           input logic err_exp, input logic [15:0] st_exp);
        n_tests++;
        if ((err_act !== err_exp) || (st_act !== st_exp)) begin
            n_fail++;
            $display("FAIL %s: mem_error/stall_cycles got %b/%0d expected %b/%0d",
                     nm, err_act, st_act, err_exp, st_exp);
        end
    endtask

    // One cycle of hand stimulus; ld=1 presents a src2 load-use match on r5.
    task automatic cyc(input string nm, input logic r, input logic ld_i, input logic br_i,
                       input logic mq_i, input logic md_i, input logic [5:0] exp, input bit use_b);
        @(negedge clk);
        rst = r; br = br_i; mq = mq_i; md = md_i; ld = ld_i;
        src1 = 6'd0; u1 = 1'b0;
        src2 = ld_i ? 6'd5 : 6'd0; u2 = ld_i; rd = ld_i ? 6'd5 : 6'd0;
        #1;
        if (use_b) chk_ctl(nm, {pc_b, ifen_b, iff_b, bub_b, exf_b, hold_b}, exp);
        else       chk_ctl(nm, {pc_a, ifen_a, iff_a, bub_a, exf_a, hold_a}, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; src1 = 6'd0; src2 = 6'd0; rd = 6'd0;
        u1 = 1'b0; u2 = 1'b0; ld = 1'b0; br = 1'b0; mq = 1'b0; md = 1'b0;

        tv[0]  = mk(1'b1, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd0);
        tv[1]  = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd0);
        tv[2]  = mk(1'b0, 6'd0,1'b0, 6'd5,1'b1, 6'd5,1'b1, 1'b0,1'b0,1'b0, BUB,   1'b0, 16'd1);
        tv[3]  = mk(1'b0, 6'd0,1'b0, 6'd5,1'b1, 6'd0,1'b0, 1'b0,1'b0,1'b0, BUB,   1'b0, 16'd2);
        tv[4]  = mk(1'b0, 6'd0,1'b0, 6'd5,1'b1, 6'd0,1'b0, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd2);
        tv[5]  = mk(1'b0, 6'd5,1'b0, 6'd5,1'b0, 6'd5,1'b1, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd2);
        tv[6]  = mk(1'b0, 6'd7,1'b1, 6'd3,1'b0, 6'd7,1'b1, 1'b0,1'b0,1'b0, BUB,   1'b0, 16'd3);
        tv[7]  = mk(1'b0, 6'd7,1'b1, 6'd3,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, BUB,   1'b0, 16'd4);
        tv[8]  = mk(1'b0, 6'd7,1'b1, 6'd5,1'b1, 6'd7,1'b0, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd4);
        tv[9]  = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b1,1'b0,1'b0, FLUSH, 1'b0, 16'd4);
        tv[10] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd4);
        tv[11] = mk(1'b0, 6'd0,1'b0, 6'd5,1'b1, 6'd5,1'b1, 1'b1,1'b0,1'b0, FLUSH, 1'b0, 16'd4);
        tv[12] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd4);
        tv[13] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b1,1'b0, FRZ,   1'b0, 16'd5);
        tv[14] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, FRZ,   1'b0, 16'd6);
        tv[15] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, FRZ,   1'b0, 16'd7);
        tv[16] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b1, REL,   1'b0, 16'd8);
        tv[17] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd8);
        tv[18] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b1,1'b1, IDLE,  1'b0, 16'd8);
        tv[19] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b1,1'b1,1'b1, FLUSH, 1'b0, 16'd8);
        tv[20] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b1,1'b1,1'b0, FRZ,   1'b0, 16'd9);
        tv[21] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b1, REL,   1'b0, 16'd10);
        tv[22] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd10);
        tv[23] = mk(1'b0, 6'd0,1'b0, 6'd5,1'b1, 6'd5,1'b1, 1'b0,1'b0,1'b0, BUB,   1'b0, 16'd11);
        tv[24] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b1,1'b0, FRZ,   1'b0, 16'd12);
        tv[25] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b1, REL,   1'b0, 16'd13);
        tv[26] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, BUB,   1'b0, 16'd14);
        tv[27] = mk(1'b0, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd14);
        tv[28] = mk(1'b0, 6'd0,1'b0, 6'd5,1'b1, 6'd5,1'b1, 1'b0,1'b0,1'b0, BUB,   1'b0, 16'd15);
        tv[29] = mk(1'b1, 6'd0,1'b0, 6'd5,1'b1, 6'd5,1'b1, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd0);
        tv[30] = mk(1'b0, 6'd0,1'b0, 6'd5,1'b1, 6'd6,1'b1, 1'b0,1'b0,1'b0, IDLE,  1'b0, 16'd0);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            rst = tv[i].rst; src1 = tv[i].s1; u1 = tv[i].u1; src2 = tv[i].s2; u2 = tv[i].u2;
            rd = tv[i].rd; ld = tv[i].ld; br = tv[i].br; mq = tv[i].mq; md = tv[i].md;
            #1;
            chk_ctl($sformatf("vec%0d", i), {pc_a, ifen_a, iff_a, bub_a, exf_a, hold_a}, tv[i].ctl);
            @(posedge clk);
            #1;
            chk_reg($sformatf("vec%0d_reg", i), err_a, stall_a, tv[i].err, tv[i].stall);
        end

        // Timeout on MEM_TIMEOUT=4: hold for 4 cycles, abort on the fifth.
        cyc("to_t0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
        cyc("to_t1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ, 1'b0);
        cyc("to_t2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ, 1'b0);
        cyc("to_t3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ, 1'b0);
        chk_reg("to_before_abort", err_a, stall_a, 1'b0, 16'd4);
        cyc("to_t4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REL, 1'b0);
        chk_reg("to_abort", err_a, stall_a, 1'b1, 16'd5);
        cyc("to_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b0);
        cyc("to_run_hz", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BUB, 1'b0);
        cyc("to_run_hz2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BUB, 1'b0);
        cyc("to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b0);
        chk_reg("to_sticky", err_a, stall_a, 1'b1, 16'd7);

        // Reset in the middle of a memory wait.
        cyc("rmw_t0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
        cyc("rmw_t1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ, 1'b0);
        chk_reg("rmw_pre", err_a, stall_a, 1'b1, 16'd9);
        cyc("rmw_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b0);
        chk_reg("rmw_cleared", err_a, stall_a, 1'b0, 16'd0);
        cyc("rmw_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b0);
        chk_reg("rmw_after_reg", err_a, stall_a, 1'b0, 16'd0);

        // LOAD_BUBBLES=3 with a memory freeze in the middle of the load stall.
        cyc("ls3_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b1);
        cyc("ls3_t0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BUB, 1'b1);
        cyc("ls3_t1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b1);
        cyc("ls3_t2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ, 1'b1);
        cyc("ls3_t3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, REL, 1'b1);
        cyc("ls3_t4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BUB, 1'b1);
        cyc("ls3_t5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BUB, 1'b1);
        chk_reg("ls3_stall", err_b, stall_b, 1'b0, 16'd6);
        cyc("ls3_t6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b1);
        chk_reg("ls3_end", err_b, stall_b, 1'b0, 16'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
